// File: rtl/reg_dump_serializer.sv
// Snapshots sixteen 16-bit register taps on request and streams them as a
// 34-byte frame (header, big-endian data w0 first, XOR checksum) over valid/ready.
module reg_dump_serializer #(
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] w0,
    input  logic [15:0] w1,
    input  logic [15:0] w2,
    input  logic [15:0] w3,
    input  logic [15:0] w4,
    input  logic [15:0] w5,
    input  logic [15:0] w6,
    input  logic [15:0] w7,
    input  logic [15:0] w8,
    input  logic [15:0] w9,
    input  logic [15:0] w10,
    input  logic [15:0] w11,
    input  logic [15:0] w12,
    input  logic [15:0] w13,
    input  logic [15:0] w14,
    input  logic [15:0] w15,
    input  logic        snap_req,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        req_dropped
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] w_s      [NUM_REGS];
    logic [15:0] shadow_r [NUM_REGS];
    logic [3:0]  idx_r, idx_s;
    logic [7:0]  csum_r, csum_s;
    logic [7:0]  data_r, data_s;
    logic        valid_r, valid_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        drop_r, drop_s;
    logic        load_s;
    logic        hs_s;

    assign w_s[0]  = w0;
    assign w_s[1]  = w1;
    assign w_s[2]  = w2;
    assign w_s[3]  = w3;
    assign w_s[4]  = w4;
    assign w_s[5]  = w5;
    assign w_s[6]  = w6;
    assign w_s[7]  = w7;
    assign w_s[8]  = w8;
    assign w_s[9]  = w9;
    assign w_s[10] = w10;
    assign w_s[11] = w11;
    assign w_s[12] = w12;
    assign w_s[13] = w13;
    assign w_s[14] = w14;
    assign w_s[15] = w15;

    // Next-state and next-output decode; outputs are computed one step ahead so they leave flops.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        csum_s  = csum_r;
        data_s  = data_r;
        valid_s = valid_r;
        done_s  = 1'b0;
        drop_s  = drop_r;
        load_s  = 1'b0;
        hs_s    = valid_r & out_ready;

        if (busy_r && snap_req) begin
            drop_s = 1'b1;
        end else begin
            drop_s = drop_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (snap_req) begin
                    load_s  = 1'b1;
                    csum_s  = 8'h00;
                    drop_s  = 1'b0;
                    state_s = ST_HDR;
                    valid_s = 1'b1;
                    data_s  = HDR_BYTE;
                end else begin
                    valid_s = 1'b0;
                    data_s  = 8'h00;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
                    idx_s   = 4'd0;
                    state_s = ST_HI;
                    data_s  = shadow_r[0][15:8];
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_HI: begin
                if (hs_s) begin
                    csum_s  = csum_update(csum_r, data_r);
                    state_s = ST_LO;
                    data_s  = shadow_r[idx_r][7:0];
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_LO: begin
                if (hs_s) begin
                    csum_s = csum_update(csum_r, data_r);
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_CSUM;
                        data_s  = csum_s;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        state_s = ST_HI;
                        data_s  = shadow_r[idx_r + 4'd1][15:8];
                    end
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_CSUM: begin
                if (hs_s) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    data_s  = 8'h00;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                data_s  = 8'h00;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // FSM state, stream index, checksum and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            csum_r  <= 8'h00;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            csum_r  <= csum_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            drop_r  <= drop_s;
        end
    end

    // Shadow copy of the register taps, frozen for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= 16'h0000;
            end
        end else if (load_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= w_s[i];
            end
        end
    end

    assign out_data    = data_r;
    assign out_valid   = valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign req_dropped = drop_r;

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Self-checking bench for reg_dump_serializer: directed scenarios with random
// register contents and ready patterns, checked against a frame-level model.
module tb_reg_dump_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] wv [16];
    logic        snap_req;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        req_dropped;

    int checks;
    int failures;
    int frame_cycles;
    int busy_cycles;
    logic [15:0] cap [16];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];

    reg_dump_serializer dut (
        .clk(clk), .rst(rst),
        .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]),
        .w4(wv[4]), .w5(wv[5]), .w6(wv[6]), .w7(wv[7]),
        .w8(wv[8]), .w9(wv[9]), .w10(wv[10]), .w11(wv[11]),
        .w12(wv[12]), .w13(wv[13]), .w14(wv[14]), .w15(wv[15]),
        .snap_req(snap_req),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .req_dropped(req_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame from the captured register values.
    task automatic build_expected();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(cap[i][15:8]);
            exp_q.push_back(cap[i][7:0]);
            x = x ^ cap[i][15:8] ^ cap[i][7:0];
        end
        exp_q.push_back(x);
    endtask

    task automatic compare_frame(input string tag);
        build_expected();
        check({tag, "_len"}, got.size(), 34);
        for (int i = 0; i < 34 && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 16; i++) wv[i] = 16'($urandom);
    endtask

    task automatic start_frame();
        snap_req = 1'b1;
        cap = wv;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    // Collect accepted bytes; optionally pulse snap_req once when drop_at bytes are in.
    task automatic collect(input int pct, input int drop_at);
        int cyc;
        logic pv, pr, dropped;
        logic [7:0] pd;
        got.delete();
        busy_cycles = 0;
        cyc = 0;
        pv = 1'b0; pr = 1'b1; pd = 8'h00; dropped = 1'b0;
        while (got.size() < 34 && cyc < 3000) begin
            if (busy) busy_cycles++;
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
            end
            if (drop_at >= 0 && !dropped && got.size() == drop_at) begin
                snap_req = 1'b1;
                dropped = 1'b1;
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_valid && out_ready) got.push_back(out_data);
            pv = out_valid; pr = out_ready; pd = out_data;
            @(posedge clk); #1;
            snap_req = 1'b0;
            cyc++;
        end
        frame_cycles = cyc;
        check("frame_timeout", got.size(), 34);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("valid_after", out_valid, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        snap_req = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) wv[i] = 16'h0000;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
            check("idle_outs", {out_data, out_valid, busy, done, req_dropped}, 32'h0);
        end

        // Basic frame with ready high
        for (int i = 0; i < 16; i++) wv[i] = 16'h1000 + 16'(i);
        start_frame();
        check("hdr_latency", {out_valid, out_data}, {1'b1, 8'hA5});
        collect(100, -1);
        check("basic_cycles", frame_cycles, 34);
        check("basic_busy", busy_cycles, 34);
        compare_frame("basic");
        @(posedge clk); #1;
        check("done_once", done, 0);

        // Checksum and atomicity
        for (int i = 0; i < 16; i++) wv[i] = 16'h0000;
        wv[3] = 16'hBEEF;
        start_frame();
        wv[3] = 16'h1234;
        collect(100, -1);
        check("atom_b7", got[7], 8'hBE);
        check("atom_b8", got[8], 8'hEF);
        check("atom_csum", got[33], 8'h51);
        compare_frame("atom");
        @(posedge clk); #1;

        // Backpressure on the basic frame
        for (int i = 0; i < 16; i++) wv[i] = 16'h1000 + 16'(i);
        start_frame();
        collect(30, -1);
        compare_frame("bp");
        @(posedge clk); #1;

        // Random contents with backpressure
        for (int f = 0; f < 3; f++) begin
            randomize_regs();
            start_frame();
            collect(50, -1);
            compare_frame("rand");
            @(posedge clk); #1;
        end

        // Dropped request mid-frame, then back-to-back request in the done cycle
        randomize_regs();
        start_frame();
        collect(100, 10);
        check("drop_sticky", req_dropped, 1);
        compare_frame("drop");
        randomize_regs();
        start_frame();
        check("b2b_hdr", {out_valid, out_data}, {1'b1, 8'hA5});
        check("b2b_drop_clr", req_dropped, 0);
        collect(100, -1);
        compare_frame("b2b");
        @(posedge clk); #1;

        // Asynchronous reset during byte 12
        randomize_regs();
        start_frame();
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", {out_valid, busy, done}, 32'h0);
        randomize_regs();
        start_frame();
        check("arst_hdr", {out_valid, out_data}, {1'b1, 8'hA5});
        collect(70, -1);
        compare_frame("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
